mic_frame_packer: RTL
=====================

Name: mic_frame_packer

Overview:
- Front-end packer that feeds the GCC-PHAT core's S_AXIS_DATA input (128-bit AXI-Stream slave).
- Takes a serial, channel-interleaved PCM sample stream from the mic capture logic and packs NUM_CH samples into one DATA_WIDTH word.
- Buffers packed words in a small first-word-fall-through (FWFT) FIFO and drives them out as an AXI-Stream master, with tlast marking each FRAME_LEN-word analysis frame.
- Reports loss of channel sync and FIFO overflow.

Parameters:
- NUM_CH, 8, channels per packed word.
- SAMPLE_WIDTH, 16, bits per PCM sample.
- DATA_WIDTH, 128, output word width; must equal NUM_CH*SAMPLE_WIDTH.
- FRAME_LEN, 256, words per frame; tlast is set on the last word; must be >= 2.
- FIFO_DEPTH, 16, output FIFO depth in words; must be a power of 2.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  sample strobe; one sample per asserted cycle; no backpressure.
- s_first  in  1  qualifies s_data as channel 0; only meaningful when s_valid=1.
- s_data  in  SAMPLE_WIDTH  PCM sample.
- M_AXIS_DATA_tdata  out  DATA_WIDTH  packed word; channel k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- M_AXIS_DATA_tvalid  out  1  FIFO not empty.
- M_AXIS_DATA_tready  in  1  downstream accept.
- M_AXIS_DATA_tlast  out  1  last word of a frame.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.
- clear_overflow  in  1  synchronous clear of overflow.
- sync_err  out  1  one-cycle pulse on a channel-sync violation.

Behaviour:
- Reset (async assert, sync release): state=HUNT, ch=0, frame count=0, FIFO empty.
  - Output reset values: tvalid=0, tlast=0, tdata=0, overflow=0, sync_err=0.
- Packing FSM, states HUNT and PACK; ch index has width clog2(NUM_CH).
- HUNT:
  - Samples with s_first=0 are ignored.
  - s_valid&s_first: the sample is stored as channel 0, ch<=1, go to PACK.
- PACK, on each s_valid cycle:
  - s_first=1 with ch!=0: pulse sync_err, discard the partial word, store the sample as channel 0, ch<=1.
  - s_first=0 with ch==0: pulse sync_err, discard the sample, go to HUNT.
  - Otherwise: store the sample into slot ch.
    - ch==NUM_CH-1: push {current s_data, slots NUM_CH-2..0} into the FIFO on the same edge, ch<=0.
    - Otherwise ch<=ch+1.
- Latency: the word is visible at the FIFO output (tvalid=1) the cycle after the edge that accepted the last sample, provided the FIFO was empty.
- Output handshake:
  - A beat transfers on tvalid&tready.
  - tdata and tlast stay stable while tvalid&!tready.
  - tvalid never drops without a transfer.
- FIFO:
  - Stores DATA_WIDTH+1 bits per entry (the extra bit is tlast).
  - Push and pop in the same cycle while full: the push is accepted and occupancy is unchanged.
  - Push while full with no pop: the word is dropped and overflow<=1. The frame counter does not advance, so no tlast is lost.
- Frame counter:
  - Counts pushed words 0..FRAME_LEN-1.
  - The word pushed at count FRAME_LEN-1 carries tlast=1, and the counter wraps to 0.
  - A sync_err does not reset the counter.
- overflow:
  - clear_overflow clears it.
  - A drop in the same cycle as clear_overflow wins (the flag stays set).
- rst_n asserted mid-frame or mid-transfer: everything is cleared immediately, FIFO contents are lost, and tvalid falls asynchronously.

Test Plan:
- Reset, then 8 samples 0x0000..0x0007 (first on the 0x0000 sample), tready=1 -> one beat, tdata=0x0007_0006_0005_0004_0003_0002_0001_0000, tvalid one cycle after the 8th sample, tlast=0, sync_err never pulses.
- Stream of 256 words with tready=1 -> tlast=1 only on the 256th beat; word 257 has tlast=0.
- tready=0 during 17 complete words (FIFO_DEPTH=16) -> first 16 retained, overflow=1 at the 17th push. tready=1 afterwards -> 16 beats out in order. clear_overflow -> overflow=0.
- s_first asserted on the 5th sample of a word -> sync_err pulses once, partial discarded; the next emitted word starts from that sample.
- 3 samples with s_first=0 after reset -> no output; then a normal 8-sample group -> exactly one word.
- rst_n pulled low while 3 words are buffered and tvalid=1 -> tvalid=0, overflow=0 immediately; no beats after release until new samples arrive.

Source files
------------

// File: rtl/mic_frame_packer.sv
// Packs a channel-interleaved PCM sample stream into NUM_CH-wide words, buffers
// them in a small FWFT FIFO and streams them out as an AXI-Stream master with
// tlast marking the final word of each FRAME_LEN-word frame.
module mic_frame_packer #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned FRAME_LEN    = 256,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic                    s_first,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0]   M_AXIS_DATA_tdata,
  output logic                    M_AXIS_DATA_tvalid,
  input  logic                    M_AXIS_DATA_tready,
  output logic                    M_AXIS_DATA_tlast,
  output logic                    overflow,
  input  logic                    clear_overflow,
  output logic                    sync_err
);

  localparam int unsigned CW  = $clog2(NUM_CH);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FW  = $clog2(FRAME_LEN);
  localparam int unsigned SLW = (NUM_CH - 1) * SAMPLE_WIDTH;

  typedef enum logic [0:0] {StHunt, StPack} state_e;

  state_e                  state_q;
  logic [CW-1:0]           ch_q;
  logic [SLW-1:0]          slot_q;
  logic                    sync_err_q;

  logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_q;
  logic [AW-1:0]           rd_q;
  logic [AW:0]             count_q;
  logic [FW-1:0]           frame_q;
  logic                    overflow_q;

  logic                    last_ch;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    push_ok;
  logic                    drop;
  logic                    tlast_in;
  logic [DATA_WIDTH-1:0]   push_word;
  logic [DATA_WIDTH:0]     rd_word;

  assign last_ch   = (ch_q == CW'(NUM_CH - 1));
  // Final sample of a well-formed word completes the push on this same edge.
  assign push      = s_valid && (state_q == StPack) && !s_first && last_ch;
  assign pop       = M_AXIS_DATA_tvalid && M_AXIS_DATA_tready;
  assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign tlast_in  = (frame_q == FW'(FRAME_LEN - 1));
  assign push_word = {s_data, slot_q};

  // Packing FSM: hunts for channel 0, then collects one sample per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      ch_q       <= '0;
      slot_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      sync_err_q <= 1'b0;
      if (s_valid) begin
        case (state_q)
          StHunt: begin
            if (s_first) begin
              slot_q[SAMPLE_WIDTH-1:0] <= s_data;
              ch_q                     <= CW'(1);
              state_q                  <= StPack;
            end
          end
          StPack: begin
            if (s_first) begin
              // Early channel 0 restarts the word; the partial is overwritten.
              if (ch_q != '0) sync_err_q <= 1'b1;
              slot_q[SAMPLE_WIDTH-1:0] <= s_data;
              ch_q                     <= CW'(1);
            end else if (ch_q == '0) begin
              sync_err_q <= 1'b1;
              state_q    <= StHunt;
            end else if (last_ch) begin
              ch_q <= '0;
            end else begin
              for (int k = 1; k < NUM_CH - 1; k++) begin
                if (ch_q == CW'(k)) slot_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_data;
              end
              ch_q <= ch_q + CW'(1);
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

  // FIFO pointers, occupancy, frame position and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      frame_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_q    <= wr_q + AW'(1);
        frame_q <= tlast_in ? '0 : frame_q + FW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      // A drop beats a simultaneous clear so no loss goes unreported.
      if (drop) overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // FIFO storage; entry holds {tlast, word}.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= {tlast_in, push_word};
  end

  // FWFT read port; outputs are forced to zero while empty.
  always_comb begin
    rd_word            = mem[rd_q];
    M_AXIS_DATA_tvalid = (count_q != '0);
    M_AXIS_DATA_tdata  = M_AXIS_DATA_tvalid ? rd_word[DATA_WIDTH-1:0] : '0;
    M_AXIS_DATA_tlast  = M_AXIS_DATA_tvalid & rd_word[DATA_WIDTH];
  end

  assign overflow = overflow_q;
  assign sync_err = sync_err_q;

endmodule
